// File: rtl/uart_tx_64.sv
// 64-bit word to eight back-to-back UART 8N1 frames, low byte first, LSB first; start bit drives the line on the accept edge.
// One word in flight: requests while tx_busy are dropped, and a request in the data_in_done cycle is taken with no idle gap.
module uart_tx_64 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_64,
  input  logic        data_in_enable,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        data_in_done
);

  // BPS_CNT must be at least 2 for the bit-period counter to be meaningful.
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] BPS_LAST = CNT_W'(BPS_CNT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] bps_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [63:0]      shift_q;
  logic             bit_end;
  logic             accept;

  assign bit_end = (bps_cnt == BPS_LAST);
  assign accept  = data_in_enable && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bps_cnt      <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      shift_q      <= '0;
      uart_txd     <= 1'b1;
      tx_busy      <= 1'b0;
      data_in_done <= 1'b0;
    end else begin
      data_in_done <= 1'b0;
      case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          if (accept) begin
            shift_q  <= data_64;
            state    <= START;
            tx_busy  <= 1'b1;
            uart_txd <= 1'b0;
            bps_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end

        START: begin
          if (bit_end) begin
            bps_cnt  <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_txd <= shift_q[0];
          end else begin
            bps_cnt <= bps_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            bps_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shift_q[bit_idx + 3'd1];
            end
          end else begin
            bps_cnt <= bps_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            bps_cnt <= '0;
            if (byte_idx == 3'd7) begin
              state        <= IDLE;
              tx_busy      <= 1'b0;
              data_in_done <= 1'b1;
              uart_txd     <= 1'b1;
            end else begin
              // Next byte moves into the low lane; its start bit follows the stop bit directly.
              byte_idx <= byte_idx + 3'd1;
              shift_q  <= {8'h00, shift_q[63:8]};
              state    <= START;
              uart_txd <= 1'b0;
            end
          end else begin
            bps_cnt <= bps_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          tx_busy  <= 1'b0;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule
